seq_gen: RTL and testbench
==========================

SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter: LEN_W, default 4, width of each run-length input and of the internal run counter.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: start  input  1  request to emit one sequence; sampled only in IDLE.
REQ-005 Port: len1  input  LEN_W  number of cycles num=1 is driven; latched on accepted start.
REQ-006 Port: len2  input  LEN_W  number of cycles num=2 is driven; latched on accepted start.
REQ-007 Port: len3  input  LEN_W  number of cycles num=3 is driven; latched on accepted start.
REQ-008 Port: num  output  2  symbol stream for the downstream counting detector; registered.
REQ-009 Port: busy  output  1  high while a sequence is being emitted (states S1, S2, S3); registered.
REQ-010 Port: done  output  1  one-cycle pulse after the last num=3 cycle; registered.

Function
REQ-011 The block SHALL implement the states IDLE, S1, S2, S3 and DONE.
REQ-012 In IDLE the block SHALL drive num=0, busy=0 and done=0.
REQ-013 In IDLE, when start=1 is sampled, the block SHALL latch len1, len2 and len3 and enter S1 on the same edge.
REQ-014 After an accepted start, num=1 and busy=1 SHALL be visible from the cycle after the sampling edge (latency 1).
REQ-015 S1 SHALL drive num=1 for exactly max(len1,1) cycles, then transition to S2.
REQ-016 S2 SHALL drive num=2 for exactly max(len2,1) cycles, then transition to S3.
REQ-017 S3 SHALL drive num=3 for exactly max(len3,1) cycles, then transition to DONE.
REQ-018 A latched length of 0 SHALL be treated as 1; the maximum run is 2^LEN_W-1 cycles, and the counter SHALL NOT wrap.
REQ-019 DONE SHALL last exactly one cycle with num=0, busy=0 and done=1, then return to IDLE.
REQ-020 start SHALL be ignored in S1, S2, S3 and DONE; a start held high through DONE SHALL be accepted in the following IDLE cycle.
REQ-021 Changes to len1, len2 or len3 after acceptance SHALL NOT affect the sequence in progress.
REQ-022 The total number of busy cycles per sequence SHALL equal max(len1,1)+max(len2,1)+max(len3,1).
REQ-023 Each new run SHALL start on the cycle immediately after the previous run ends; there SHALL be no gap cycles between runs.

Reset
REQ-024 When reset=1 is sampled, the block SHALL enter IDLE with num=0, busy=0, done=0 and the run counter at 0.
REQ-025 Reset SHALL take priority over start and over any state transition.
REQ-026 Reset asserted mid-sequence SHALL abort the sequence with no done pulse.
REQ-027 The first start SHALL be accepted on the first edge with reset=0 and start=1.

Verification
REQ-028 The bench SHALL cover: reset, then start with len1=1, len2=2, len3=1 -> num = 1,2,2,3, then DONE (num=0, done=1), then IDLE; busy high for exactly 4 cycles.
REQ-029 The bench SHALL cover: len1=0, len2=0, len3=0 -> num = 1,2,3, with busy high for 3 cycles and one done pulse.
REQ-030 The bench SHALL cover: len1=2, len2=1, len3=2 with start held high continuously -> two back-to-back sequences 1,1,2,3,3 separated by exactly one DONE cycle and one IDLE cycle.
REQ-031 The bench SHALL cover: reset asserted during the second num=2 cycle of len=(1,3,1) -> next cycle shows num=0, busy=0, done=0, and no done pulse follows.
REQ-032 The bench SHALL cover: len inputs changed to (5,5,5) during S1 of a (1,1,1) sequence -> the output stays 1,2,3.
REQ-033 The bench SHALL cover: len1=15, len2=15, len3=15 (LEN_W=4) -> 15 cycles of each symbol, 45 busy cycles, no counter wrap.

Source files
------------

// File: rtl/seq_gen.sv
// Three-run symbol generator: emits num=1, 2, 3 for latched run lengths, then a one-cycle done.
// All outputs are registered and follow the state entered on the same edge.
module seq_gen #(
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len1,
    input  logic [LEN_W-1:0] len2,
    input  logic [LEN_W-1:0] len3,
    output logic [1:0]       num,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        StIdle,
        StS1,
        StS2,
        StS3,
        StDone
    } state_e;

    state_e state_q, state_d;

    // cnt holds the cycles still to go in the current run, minus one
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len2_q, len2_d;
    logic [LEN_W-1:0] len3_q, len3_d;

    logic [1:0] num_d;
    logic       busy_d;
    logic       done_d;

    // A zero length runs for one cycle, same as a length of one.
    function automatic logic [LEN_W-1:0] last_idx(input logic [LEN_W-1:0] len);
        return (len == '0) ? '0 : len - LEN_W'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len2_d  = len2_q;
        len3_d  = len3_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StS1;
                    cnt_d   = last_idx(len1);
                    len2_d  = len2;
                    len3_d  = len3;
                end
            end
            StS1: begin
                if (cnt_q == '0) begin
                    state_d = StS2;
                    cnt_d   = last_idx(len2_q);
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            StS2: begin
                if (cnt_q == '0) begin
                    state_d = StS3;
                    cnt_d   = last_idx(len3_q);
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            StS3: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they appear one cycle after the deciding edge.
    always_comb begin
        num_d  = 2'd0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            StS1: begin
                num_d  = 2'd1;
                busy_d = 1'b1;
            end
            StS2: begin
                num_d  = 2'd2;
                busy_d = 1'b1;
            end
            StS3: begin
                num_d  = 2'd3;
                busy_d = 1'b1;
            end
            StDone: begin
                done_d = 1'b1;
            end
            default: begin
                num_d  = 2'd0;
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len2_q  <= '0;
            len3_q  <= '0;
            num     <= 2'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len2_q  <= len2_d;
            len3_q  <= len3_d;
            num     <= num_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: directed scenarios plus random lengths, checked cycle by cycle against
// an expected-output queue built from the run-length rules.
module tb_seq_gen;

    localparam int LW = 4;

    logic          clk;
    logic          reset;
    logic          start;
    logic [LW-1:0] len1;
    logic [LW-1:0] len2;
    logic [LW-1:0] len3;
    logic [1:0]    num;
    logic          busy;
    logic          done;

    seq_gen #(
        .LEN_W(LW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .len1 (len1),
        .len2 (len2),
        .len3 (len3),
        .num  (num),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] num;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   total;
    int   bad;
    int   busy_seen;

    function automatic int eff(input int l);
        return (l == 0) ? 1 : l;
    endfunction

    task automatic push_run(input logic [1:0] sym, input int n);
        for (int i = 0; i < n; i++) q.push_back({sym, 1'b1, 1'b0});
    endtask

    task automatic push_seq(input int l1, input int l2, input int l3);
        push_run(2'd1, eff(l1));
        push_run(2'd2, eff(l2));
        push_run(2'd3, eff(l3));
        q.push_back({2'd0, 1'b0, 1'b1});
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) q.push_back({2'd0, 1'b0, 1'b0});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input exp_t e);
        total++;
        assert ({num, busy, done} === e) else begin
            bad++;
            $error("FAIL %s: got num=%0d busy=%0b done=%0b, want num=%0d busy=%0b done=%0b",
                   tag, num, busy, done, e.num, e.busy, e.done);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int want);
        total++;
        assert (got == want) else begin
            bad++;
            $error("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    task automatic run_exp(input string tag);
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (busy === 1'b1) busy_seen++;
            chk(tag, e);
            tick();
        end
    endtask

    task automatic start_seq(input int l1, input int l2, input int l3);
        len1  = LW'(l1);
        len2  = LW'(l2);
        len3  = LW'(l3);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int l1, l2, l3;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        len1  = '0;
        len2  = '0;
        len3  = '0;
        tick();
        start = 1'b1;
        tick();
        chk("reset_idle", {2'd0, 1'b0, 1'b0});
        start = 1'b0;

        // (1,2,1) accepted on the first edge with reset low
        reset     = 1'b0;
        busy_seen = 0;
        start_seq(1, 2, 1);
        push_seq(1, 2, 1);
        push_idle(2);
        run_exp("seq_121");
        chk_int("busy_121", busy_seen, 4);

        // zero lengths behave as one
        busy_seen = 0;
        start_seq(0, 0, 0);
        push_seq(0, 0, 0);
        push_idle(1);
        run_exp("seq_000");
        chk_int("busy_000", busy_seen, 3);

        // start held: two sequences separated by one DONE and one IDLE cycle
        busy_seen = 0;
        len1  = LW'(2);
        len2  = LW'(1);
        len3  = LW'(2);
        start = 1'b1;
        tick();
        push_seq(2, 1, 2);
        push_idle(1);
        push_seq(2, 1, 2);
        run_exp("held_212");
        start = 1'b0;
        push_idle(2);
        run_exp("held_after");
        chk_int("busy_held", busy_seen, 10);

        // reset during the second num=2 cycle aborts with no done pulse
        start_seq(1, 3, 1);
        q.push_back({2'd1, 1'b1, 1'b0});
        q.push_back({2'd2, 1'b1, 1'b0});
        run_exp("abort_pre");
        chk("abort_s2b", {2'd2, 1'b1, 1'b0});
        reset = 1'b1;
        tick();
        chk("abort_rst", {2'd0, 1'b0, 1'b0});
        reset = 1'b0;
        tick();
        push_idle(5);
        run_exp("abort_idle");

        // length inputs changed after acceptance are ignored
        start_seq(1, 1, 1);
        len1 = LW'(5);
        len2 = LW'(5);
        len3 = LW'(5);
        push_seq(1, 1, 1);
        push_idle(1);
        run_exp("late_len");

        // maximum lengths, no counter wrap
        busy_seen = 0;
        start_seq(15, 15, 15);
        push_seq(15, 15, 15);
        push_idle(2);
        run_exp("max_len");
        chk_int("busy_max", busy_seen, 45);

        // random lengths, with length inputs scrambled mid-sequence
        for (int it = 0; it < 24; it++) begin
            l1 = int'($urandom_range(0, 15));
            l2 = int'($urandom_range(0, 15));
            l3 = int'($urandom_range(0, 15));
            push_idle(int'($urandom_range(0, 2)));
            run_exp("rnd_gap");
            busy_seen = 0;
            start_seq(l1, l2, l3);
            len1 = LW'($urandom);
            len2 = LW'($urandom);
            len3 = LW'($urandom);
            push_seq(l1, l2, l3);
            run_exp("rnd_seq");
            chk_int("rnd_busy", busy_seen, eff(l1) + eff(l2) + eff(l3));
        end
        push_idle(1);
        run_exp("final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
